// File: rtl/inst_fetch_if.sv
// Instruction-bus bundle between the fetch stage (master) and the instruction
// memory / bus slave (slave). Both sides share the core clk/rst.
//
// Handshake: the master holds ibus_req=1 with ibus_addr stable until the slave
// answers with a single-cycle ibus_ack carrying ibus_rdata. The ack may come in
// the very first req cycle. There is no slave-side ready; any number of wait
// cycles is legal. Dropping req (reset) abandons the transfer, and the slave
// is expected to forget it.
interface inst_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  modport master (
    output ibus_req,
    output ibus_addr,
    input  ibus_ack,
    input  ibus_rdata
  );

  modport slave (
    input  ibus_req,
    input  ibus_addr,
    output ibus_ack,
    output ibus_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, runs the req/ack instruction bus and presents
// if_pc/if_inst to the IF/ID register. Bus wait states raise stallreq_if, a
// word fetched while the pipe is stalled is parked in a one-word buffer, and
// branch (delay-slot) and flush redirects go through a one-entry pending slot.
// The presented instruction and stallreq_if depend on the ack of the current
// cycle, so they are decoded from the state register plus ibus_ack rather
// than registered.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  inst_fetch_if.master bus,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        pend_is_flush;

  logic [31:0] br_tgt;
  logic [31:0] fl_tgt;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic        capture_branch;
  logic        ack;
  logic [31:0] rdata;

  logic        req_c;
  logic [31:0] if_pc_c;
  logic [31:0] if_inst_c;
  logic        stallreq_c;

  // Only stall[0] concerns fetch; the low target bits are forced to zero.
  logic        unused_bits;
  assign unused_bits = ^{stall[5:1], branch_target_i[1:0], new_pc_i[1:0]};

  assign ack    = bus.ibus_ack;
  assign rdata  = bus.ibus_rdata;
  assign br_tgt = {branch_target_i[31:2], 2'b00};
  assign fl_tgt = {new_pc_i[31:2], 2'b00};
  assign pc_inc = pc + 32'd4;

  // A branch seen this cycle wins over an older pending one; otherwise sequential.
  always_comb begin
    next_pc = pc_inc;
    if (branch_flag_i) begin
      next_pc = br_tgt;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end
  end

  // A branch is parked only when it is not consumed right away and no flush owns the slot.
  always_comb begin
    capture_branch = branch_flag_i && !flush_i && !(pend_valid && pend_is_flush);
  end

  // Bus request and IF/ID outputs; rst forces everything quiet in the reset cycle itself.
  always_comb begin
    req_c      = 1'b0;
    if_pc_c    = 32'd0;
    if_inst_c  = 32'd0;
    stallreq_c = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          req_c = 1'b1;
          if (ack) begin
            if (!flush_i) begin
              if_pc_c   = pc;
              if_inst_c = rdata;
            end
          end else begin
            stallreq_c = 1'b1;
          end
        end
        S_HOLD: begin
          if (!flush_i) begin
            if_pc_c   = pc;
            if_inst_c = buffer;
          end
        end
        S_DISCARD: begin
          req_c      = 1'b1;
          stallreq_c = 1'b1;
        end
        default: begin
          req_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.ibus_req  = req_c;
  assign bus.ibus_addr = pc;
  assign if_pc         = if_pc_c;
  assign if_inst       = if_inst_c;
  assign stallreq_if   = stallreq_c;
  assign state_dbg     = state;

  // Fetch FSM: PC, hold buffer and pending redirect slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RESET;
      pc            <= RESET_PC;
      buffer        <= 32'd0;
      pend_valid    <= 1'b0;
      pend_pc       <= 32'd0;
      pend_is_flush <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state <= S_FETCH;
          if (flush_i) begin
            pc            <= fl_tgt;
            pend_valid    <= 1'b0;
            pend_is_flush <= 1'b0;
          end else if (capture_branch) begin
            pend_valid    <= 1'b1;
            pend_pc       <= br_tgt;
            pend_is_flush <= 1'b0;
          end
        end

        S_FETCH: begin
          if (flush_i) begin
            if (ack) begin
              // Word arrived together with the flush: drop it and refetch now.
              pc            <= fl_tgt;
              pend_valid    <= 1'b0;
              pend_is_flush <= 1'b0;
            end else begin
              // Request is already on the bus; its answer must be swallowed.
              state         <= S_DISCARD;
              pend_valid    <= 1'b1;
              pend_pc       <= fl_tgt;
              pend_is_flush <= 1'b1;
            end
          end else if (ack && !stall[0]) begin
            pc         <= next_pc;
            pend_valid <= 1'b0;
          end else begin
            if (ack) begin
              buffer <= rdata;
              state  <= S_HOLD;
            end
            if (capture_branch) begin
              pend_valid    <= 1'b1;
              pend_pc       <= br_tgt;
              pend_is_flush <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (flush_i) begin
            pc            <= fl_tgt;
            buffer        <= 32'd0;
            pend_valid    <= 1'b0;
            pend_is_flush <= 1'b0;
            state         <= S_FETCH;
          end else if (!stall[0]) begin
            pc         <= next_pc;
            pend_valid <= 1'b0;
            state      <= S_FETCH;
          end else if (capture_branch) begin
            pend_valid    <= 1'b1;
            pend_pc       <= br_tgt;
            pend_is_flush <= 1'b0;
          end
        end

        S_DISCARD: begin
          if (ack) begin
            // A flush arriving with the ack is the newest target.
            pc            <= flush_i ? fl_tgt : pend_pc;
            pend_valid    <= 1'b0;
            pend_is_flush <= 1'b0;
            state         <= S_FETCH;
          end else if (flush_i) begin
            pend_pc <= fl_tgt;
          end
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch. A bus-slave model answers requests with
// random wait states; a transaction-level model tracks which PC must be
// delivered next and pushes {pc, inst} into exp_q at the moment stimulus makes
// a delivery due. A monitor on the falling edge pops and compares whenever the
// DUT presents an instruction to an unstalled IF/ID register, and checks the
// per-cycle bus request, address and stall request.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic [1:0]  state_dbg;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .bus             (bus),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if),
    .state_dbg       (state_dbg)
  );

  // Scoreboard and counters
  logic [63:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic run = 1'b0;

  // Per-cycle expectations from the model
  logic        exp_req;
  logic        exp_stall;
  logic        exp_addr_chk;
  logic [31:0] exp_addr;

  // Stimulus knobs
  int   p_stall   = 0;   // percent
  int   p_br      = 0;   // percent
  int   p_fl      = 0;   // percent
  int   p_rst     = 0;   // permille
  int   zero_pct  = 100; // percent of requests acked in the first cycle
  int   max_wait  = 3;
  logic force_rst = 1'b1;
  logic force_fl  = 1'b0;
  logic [31:0] force_tgt = 32'd0;
  logic stray_ack = 1'b0;

  // Bus slave state
  logic in_wait = 1'b0;
  int   wait_left = 0;

  // Reference model: next PC owed to IF/ID and the fetch situation around it
  logic [31:0] m_pc    = RESET_PC;
  logic        m_have  = 1'b0;  // word for m_pc arrived, waiting for stall to drop
  logic        m_kill  = 1'b0;  // outstanding bus answer belongs to a flushed fetch
  logic        m_idle  = 1'b1;  // first cycle after reset: no request yet
  logic        m_rv    = 1'b0;  // a taken branch is waiting for its delay slot to go
  logic [31:0] m_redir = 32'd0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic drive_cycle();
    logic ack;
    logic avail;
    @(posedge clk);
    #1;
    rst             = force_rst || ($urandom_range(0, 999) < p_rst);
    stall           = 6'($urandom_range(0, 63));
    stall[0]        = ($urandom_range(0, 99) < p_stall);
    branch_flag_i   = ($urandom_range(0, 99) < p_br);
    branch_target_i = $urandom_range(0, 32'h3FFF);
    flush_i         = force_fl || ($urandom_range(0, 99) < p_fl);
    new_pc_i        = force_fl ? force_tgt : $urandom_range(0, 32'h3FFF);
    #1;
    // bus slave
    ack = 1'b0;
    if (stray_ack) begin
      ack     = 1'b1;
      in_wait = 1'b0;
    end else if (bus.ibus_req) begin
      if (!in_wait) begin
        in_wait   = 1'b1;
        wait_left = ($urandom_range(0, 99) < zero_pct) ? 0 : $urandom_range(1, max_wait);
      end
      if (wait_left == 0) begin
        ack     = 1'b1;
        in_wait = 1'b0;
      end else begin
        wait_left = wait_left - 1;
      end
    end else begin
      in_wait = 1'b0;
    end
    bus.ibus_ack   = ack;
    bus.ibus_rdata = ack ? word_of(bus.ibus_addr) : $urandom;
    // reference model
    if (rst) begin
      exp_req      = 1'b0;
      exp_stall    = 1'b0;
      exp_addr_chk = 1'b0;
      exp_addr     = 32'd0;
      m_pc   = RESET_PC;
      m_have = 1'b0;
      m_kill = 1'b0;
      m_rv   = 1'b0;
      m_idle = 1'b1;
    end else begin
      exp_req      = !m_idle && !m_have;
      exp_stall    = m_kill || (!m_idle && !m_have && !ack);
      exp_addr_chk = !m_idle && !m_have && !m_kill;
      exp_addr     = m_pc;
      avail = m_have || (ack && !m_kill && !m_idle);
      if (flush_i) begin
        if (m_kill) m_kill = !ack;
        else        m_kill = !m_idle && !avail;
        m_pc   = align(new_pc_i);
        m_rv   = 1'b0;
        m_have = 1'b0;
      end else begin
        if (branch_flag_i && !m_kill) begin
          m_rv    = 1'b1;
          m_redir = align(branch_target_i);
        end
        if (m_kill) begin
          if (ack) m_kill = 1'b0;
        end else if (avail) begin
          if (!stall[0]) begin
            exp_q.push_back({m_pc, word_of(m_pc)});
            m_pc   = m_rv ? m_redir : m_pc + 32'd4;
            m_rv   = 1'b0;
            m_have = 1'b0;
          end else begin
            m_have = 1'b1;
          end
        end
      end
      m_idle = 1'b0;
    end
    run = 1'b1;
  endtask

  // Monitor: compare bus behaviour every cycle and pop on each real delivery.
  always @(negedge clk) begin
    logic [63:0] e;
    if (run) begin
      checks++;
      if (bus.ibus_req !== exp_req) begin
        failures++;
        $display("FAIL ibus_req t=%0t got=%b exp=%b", $time, bus.ibus_req, exp_req);
      end
      checks++;
      if (stallreq_if !== exp_stall) begin
        failures++;
        $display("FAIL stallreq_if t=%0t got=%b exp=%b", $time, stallreq_if, exp_stall);
      end
      if (exp_addr_chk) begin
        checks++;
        if (bus.ibus_addr !== exp_addr) begin
          failures++;
          $display("FAIL ibus_addr t=%0t got=%h exp=%h", $time, bus.ibus_addr, exp_addr);
        end
      end
      if (!rst && !stall[0] && if_inst != 32'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL delivery t=%0t got pc=%h inst=%h exp none", $time, if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          if ({if_pc, if_inst} !== e) begin
            failures++;
            $display("FAIL delivery t=%0t got pc=%h inst=%h exp pc=%h inst=%h",
                     $time, if_pc, if_inst, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    stall           = 6'd0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'd0;
    flush_i         = 1'b0;
    new_pc_i        = 32'd0;
    bus.ibus_ack    = 1'b0;
    bus.ibus_rdata  = 32'd0;

    // reset
    repeat (3) drive_cycle();
    force_rst = 1'b0;

    // zero-wait straight-line fetch
    repeat (30) drive_cycle();

    // wait states only
    zero_pct = 0;
    repeat (40) drive_cycle();

    // stall/hold without redirects
    zero_pct = 50;
    p_stall  = 30;
    repeat (100) drive_cycle();

    // full random mix
    p_br  = 8;
    p_fl  = 5;
    p_rst = 5;
    repeat (2500) drive_cycle();

    // wrap around the top of the address space
    p_br  = 0;
    p_fl  = 0;
    p_rst = 0;
    p_stall  = 0;
    zero_pct = 100;
    force_fl  = 1'b1;
    force_tgt = 32'hFFFF_FFF4;
    drive_cycle();
    force_fl = 1'b0;
    repeat (10) drive_cycle();

    // reset while a request waits, with stray acks during reset and S_RESET
    zero_pct = 0;
    max_wait = 3;
    repeat (2) drive_cycle();
    force_rst = 1'b1;
    stray_ack = 1'b1;
    drive_cycle();
    force_rst = 1'b0;
    drive_cycle();
    stray_ack = 1'b0;
    zero_pct  = 100;
    repeat (10) drive_cycle();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_deliveries got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
